// File: rtl/comb_arbiter.sv
// Shared comb (differentiator) stage for a multichannel CIC decimator.
// One subtractor is time-shared round-robin; each channel keeps a private delay line.
module comb_arbiter #(
    parameter int unsigned WordLengthBits = 29,
    parameter int unsigned DelayLength    = 2,
    parameter int unsigned NumChannels    = 2,
    localparam int unsigned ChanBits      = (NumChannels > 2) ? $clog2(NumChannels) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic signed [WordLengthBits-1:0] in [NumChannels],
    input  logic [NumChannels-1:0]           in_valid,
    output logic [NumChannels-1:0]           in_ready,
    output logic signed [WordLengthBits-1:0] out,
    output logic [ChanBits-1:0]              out_channel,
    output logic                             out_valid,
    input  logic                             out_ready
);

    logic [ChanBits-1:0]              rr_q, rr_d;
    logic signed [WordLengthBits-1:0] delay_q [NumChannels][DelayLength];
    logic signed [WordLengthBits-1:0] out_q, out_d;
    logic [ChanBits-1:0]              chan_q, chan_d;
    logic                             valid_q, valid_d;

    logic                             slot_free;
    logic                             accept;
    logic [NumChannels-1:0]           upper_mask;
    logic [NumChannels-1:0]           upper_req;
    logic [NumChannels-1:0]           pick_req;
    logic [NumChannels-1:0]           grant;
    logic [ChanBits-1:0]              grant_idx;
    logic                             grant_found;
    logic signed [WordLengthBits-1:0] sel_in;
    logic signed [WordLengthBits-1:0] sel_tap;
    logic signed [WordLengthBits-1:0] diff;

    // Holding rst keeps the grant off so nothing is accepted on the reset edge.
    assign slot_free = !rst && (!valid_q || out_ready);

    // Round-robin: prefer the lowest requester at or above rr_q, else wrap to the lowest.
    always_comb begin
        upper_mask = '0;
        for (int ch = 0; ch < NumChannels; ch++) begin
            upper_mask[ch] = (ch >= int'(rr_q));
        end
        upper_req = in_valid & upper_mask;
        pick_req  = (upper_req != '0) ? upper_req : in_valid;
    end

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int ch = 0; ch < NumChannels; ch++) begin
            if (!grant_found && pick_req[ch]) begin
                grant[ch]   = 1'b1;
                grant_idx   = ChanBits'(ch);
                grant_found = 1'b1;
            end
        end
    end

    assign in_ready = slot_free ? grant : '0;
    assign accept   = |in_ready;

    // One-hot mux onto the shared subtractor; wraps modulo 2^WordLengthBits.
    always_comb begin
        sel_in  = '0;
        sel_tap = '0;
        for (int ch = 0; ch < NumChannels; ch++) begin
            if (grant[ch]) begin
                sel_in  = in[ch];
                sel_tap = delay_q[ch][DelayLength-1];
            end
        end
        diff = sel_in - sel_tap;
    end

    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            rr_d = (grant_idx == ChanBits'(NumChannels - 1)) ? '0 : grant_idx + ChanBits'(1);
        end
    end

    always_comb begin
        out_d   = out_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        if (accept) begin
            out_d   = diff;
            chan_d  = grant_idx;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= '0;
            out_q   <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            out_q   <= out_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
        end
    end

    // Only the granted channel's line shifts; the others keep their history.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < NumChannels; ch++) begin
            if (rst) begin
                for (int k = 0; k < DelayLength; k++) begin
                    delay_q[ch][k] <= '0;
                end
            end else if (accept && grant[ch]) begin
                delay_q[ch][0] <= in[ch];
                for (int k = 1; k < DelayLength; k++) begin
                    delay_q[ch][k] <= delay_q[ch][k-1];
                end
            end
        end
    end

    assign out         = out_q;
    assign out_channel = chan_q;
    assign out_valid   = valid_q;

    grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
    grant_requested: assert property (@(posedge clk) disable iff (rst)
        (in_ready & ~in_valid) == '0);
    stall_no_grant: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |-> (in_ready == '0));

endmodule

// File: tb/tb_comb_arbiter.sv
// Scoreboard bench for comb_arbiter: a reference comb/round-robin model predicts
// grants and results; results are queued on accept and compared on handshake.
module tb_comb_arbiter;

    localparam int unsigned W = 29;
    localparam int unsigned N = 2;
    localparam int unsigned D = 2;

    typedef struct {
        int                  ch;
        logic signed [W-1:0] val;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic signed [W-1:0] din [N];
    logic [N-1:0]        in_valid;
    logic [N-1:0]        in_ready;
    logic signed [W-1:0] out;
    logic [0:0]          out_channel;
    logic                out_valid;
    logic                out_ready;

    // Narrow instance for the wrap-around case.
    logic signed [7:0] din_w [N];
    logic [N-1:0]      vld_w;
    logic [N-1:0]      rdy_w;
    logic signed [7:0] out_w;
    logic [0:0]        chan_w;
    logic              ovld_w;

    int errors = 0;
    int checks = 0;

    logic signed [W-1:0] m_dly [N][D];
    logic [0:0]          m_rr;
    bit                  m_valid;
    exp_t                sb [$];

    comb_arbiter #(
        .WordLengthBits(W),
        .DelayLength   (D),
        .NumChannels   (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (din),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out        (out),
        .out_channel(out_channel),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    comb_arbiter #(
        .WordLengthBits(8),
        .DelayLength   (1),
        .NumChannels   (N)
    ) dut_w (
        .clk        (clk),
        .rst        (rst),
        .in         (din_w),
        .in_valid   (vld_w),
        .in_ready   (rdy_w),
        .out        (out_w),
        .out_channel(chan_w),
        .out_valid  (ovld_w),
        .out_ready  (1'b1)
    );

    task automatic check(input string tag, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            for (int k = 0; k < D; k++) begin
                m_dly[c][k] = '0;
            end
        end
        m_rr    = '0;
        m_valid = 1'b0;
        sb.delete();
    endtask

    // One clock: predict/check at the negedge, then advance to 1 time unit past posedge.
    task automatic cycle();
        logic [N-1:0]        eg;
        logic [0:0]          ix;
        logic [0:0]          gsel;
        bit                  got;
        logic signed [W-1:0] v;
        @(negedge clk);
        eg   = '0;
        gsel = '0;
        got  = 1'b0;
        if (!rst && (!m_valid || out_ready)) begin
            for (int k = 0; k < N; k++) begin
                ix = m_rr + 1'(k);
                if (!got && in_valid[ix]) begin
                    got      = 1'b1;
                    gsel     = ix;
                    eg[ix]   = 1'b1;
                end
            end
        end
        check("in_ready", in_ready, eg);
        check("out_valid", out_valid, m_valid);
        if (m_valid) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 0, 1);
            end else begin
                check("out_data", out, sb[0].val);
                check("out_channel", out_channel, sb[0].ch);
                if (out_ready) void'(sb.pop_front());
            end
        end
        if (rst) begin
            model_reset();
        end else if (got) begin
            v = din[gsel] - m_dly[gsel][D-1];
            sb.push_back('{int'(gsel), v});
            m_dly[gsel][1] = m_dly[gsel][0];
            m_dly[gsel][0] = din[gsel];
            m_rr    = gsel + 1'b1;
            m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_chan", out_channel, 0);
        in_valid = '1;
        #1;
        check("rst_ready", in_ready, 0);
        in_valid = '0;
        rst      = 1'b0;
        model_reset();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        vld_w     = '0;
        for (int c = 0; c < N; c++) begin
            din[c]   = '0;
            din_w[c] = '0;
        end
        do_reset();

        // Single channel: 5, 7, 10 -> 5, 7, 5
        in_valid = 2'b01;
        din[0] = 5;
        cycle();
        check("t1_out0", out, 5);
        din[0] = 7;
        cycle();
        check("t1_out1", out, 7);
        din[0] = 10;
        cycle();
        check("t1_out2", out, 5);
        check("t1_chan", out_channel, 0);
        in_valid = '0;
        cycle();
        check("t1_drain", out_valid, 0);

        // Round-robin with both channels continuously valid
        do_reset();
        in_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            din[0] = W'($urandom);
            din[1] = W'($urandom);
            cycle();
            check("rr_chan", out_channel, i % 2);
        end
        in_valid = '0;
        cycle();

        // Backpressure
        do_reset();
        in_valid = 2'b01;
        din[0] = 3;
        cycle();
        out_ready = 1'b0;
        in_valid  = 2'b11;
        for (int i = 0; i < 3; i++) begin
            din[0] = W'($urandom);
            din[1] = W'($urandom);
            cycle();
            check("bp_ready", in_ready, 0);
            check("bp_hold", out, 3);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_next_chan", out_channel, 1);
        in_valid = '0;
        cycle();
        cycle();
        check("bp_sb_empty", sb.size(), 0);

        // Reset mid-stream clears history and pointer
        do_reset();
        in_valid = 2'b01;
        din[0] = 4;
        cycle();
        din[0] = 6;
        cycle();
        rst    = 1'b1;
        din[0] = 8;
        cycle();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_out", out, 0);
        rst      = 1'b0;
        in_valid = 2'b11;
        din[0]   = 9;
        din[1]   = 1;
        cycle();
        check("mid_rst_out9", out, 9);
        check("mid_rst_chan", out_channel, 0);
        in_valid = '0;
        cycle();

        // Pointer fairness
        do_reset();
        in_valid = 2'b10;
        din[1] = 20;
        cycle();
        check("fair_ch1", out_channel, 1);
        in_valid = 2'b11;
        din[0] = 30;
        din[1] = 25;
        cycle();
        check("fair_ch0", out_channel, 0);
        cycle();
        check("fair_ch1b", out_channel, 1);
        in_valid = '0;
        cycle();

        // Wrap on the 8-bit, DelayLength=1 instance: 127, 0, -128 -> 127, -127, -128
        vld_w    = 2'b01;
        din_w[0] = 8'sd127;
        cycle();
        check("wrap0", out_w, 127);
        din_w[0] = 8'sd0;
        cycle();
        check("wrap1", out_w, -127);
        din_w[0] = -8'sd128;
        cycle();
        check("wrap2", out_w, -128);
        check("wrap_valid", ovld_w, 1);
        check("wrap_chan", chan_w, 0);
        vld_w = '0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
